// File: rtl/arb_mux_2x1_pkg.sv
// Shared types and constants for the two-input round-robin arbitrating mux.
package arb_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/arb_mux_2x1_if.sv
// Requester/downstream bundle for arb_mux_2x1; master drives requests and out_ready.
interface arb_mux_2x1_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req_a;
    logic [WIDTH-1:0] data_a;
    logic             gnt_a;
    logic             req_b;
    logic [WIDTH-1:0] data_b;
    logic             gnt_b;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;

    modport master (
        output req_a, data_a, req_b, data_b, out_ready,
        input  gnt_a, gnt_b, out_valid, out_data, sel
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, out_ready,
        output gnt_a, gnt_b, out_valid, out_data, sel
    );
endinterface

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin pick; a tie goes to the source not granted last.
module rr_pick2
    import arb_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_src,
    input  logic can_accept,
    output logic gnt_a,
    output logic gnt_b
);

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (can_accept) begin
            if (req_a && req_b) begin
                gnt_a = (last_src == SRC_B);
                gnt_b = (last_src == SRC_A);
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
    end

endmodule

// File: rtl/arb_mux_2x1.sv
// Two-requester round-robin arbiter feeding a one-word output register.
// Optional grant counters enabled by defining ARB_GRANT_CNT_EN.
module arb_mux_2x1
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    arb_mux_2x1_if.slave     bus
`ifdef ARB_GRANT_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
`endif
);

    state_e           state_q, state_d;
    logic             last_src_q;
    logic             sel_q;
    logic [WIDTH-1:0] data_q;
    logic             can_accept;
    logic             granted;

    // Reset gates can_accept so no grant is issued while rst_n is low.
    always_comb begin
        bus.out_valid = (state_q == FULL);
        can_accept    = rst_n && ((state_q == EMPTY) || bus.out_ready);
        bus.out_data  = data_q;
        bus.sel       = sel_q;
    end

    rr_pick2 u_pick (
        .req_a      (bus.req_a),
        .req_b      (bus.req_b),
        .last_src   (last_src_q),
        .can_accept (can_accept),
        .gnt_a      (bus.gnt_a),
        .gnt_b      (bus.gnt_b)
    );

    assign granted = bus.gnt_a || bus.gnt_b;

    always_comb begin
        state_d = state_q;
        if (granted) begin
            state_d = FULL;
        end else if ((state_q == FULL) && bus.out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // last_src resets to B so the first tie goes to A.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q     <= '0;
            sel_q      <= SRC_A;
            last_src_q <= SRC_B;
        end else if (bus.gnt_a) begin
            data_q     <= bus.data_a;
            sel_q      <= SRC_A;
            last_src_q <= SRC_A;
        end else if (bus.gnt_b) begin
            data_q     <= bus.data_b;
            sel_q      <= SRC_B;
            last_src_q <= SRC_B;
        end
    end

`ifdef ARB_GRANT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (bus.gnt_a && (cnt_a != '1)) cnt_a <= cnt_a + 1'b1;
            if (bus.gnt_b && (cnt_b != '1)) cnt_b <= cnt_b + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb_mux_2x1.sv
// Directed bench for arb_mux_2x1: vector table plus throughput and counter sequences.
module tb_arb_mux_2x1;

    typedef struct {
        logic       rst_n;
        logic       req_a;
        logic       req_b;
        logic [7:0] data_a;
        logic [7:0] data_b;
        logic       out_ready;
        logic       gnt_a;
        logic       gnt_b;
        logic       valid;
        logic [7:0] data;
        logic       sel;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    arb_mux_2x1_if #(.WIDTH(8)) bus ();

`ifdef ARB_GRANT_CNT_EN
    logic [7:0] cnt_a, cnt_b;
`endif

    arb_mux_2x1 #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ARB_GRANT_CNT_EN
        ,
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
`endif
    );

    always #5 clk = ~clk;

    vec_t vecs[22];

    function automatic vec_t mk(logic r, logic ra, logic rb, logic [7:0] da, logic [7:0] db,
                                logic rdy, logic ga, logic gb, logic v, logic [7:0] d,
                                logic s);
        vec_t t;
        t.rst_n = r; t.req_a = ra; t.req_b = rb; t.data_a = da; t.data_b = db;
        t.out_ready = rdy; t.gnt_a = ga; t.gnt_b = gb; t.valid = v; t.data = d; t.sel = s;
        return t;
    endfunction

    task automatic check(string name, int idx, logic [7:0] act, logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    // Drive at negedge, check grants before the edge, registered outputs after it.
    task automatic step(vec_t v, int idx);
        @(negedge clk);
        rst_n         = v.rst_n;
        bus.req_a     = v.req_a;
        bus.req_b     = v.req_b;
        bus.data_a    = v.data_a;
        bus.data_b    = v.data_b;
        bus.out_ready = v.out_ready;
        #1;
        check("gnt_a", idx, {7'd0, bus.gnt_a}, {7'd0, v.gnt_a});
        check("gnt_b", idx, {7'd0, bus.gnt_b}, {7'd0, v.gnt_b});
        @(posedge clk);
        #1;
        check("out_valid", idx, {7'd0, bus.out_valid}, {7'd0, v.valid});
        check("out_data", idx, bus.out_data, v.data);
        check("sel", idx, {7'd0, bus.sel}, {7'd0, v.sel});
    endtask

    initial begin
        //            rst ra rb da     db     rdy ga gb  v  data   sel
        vecs[0]  = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        vecs[1]  = mk(0, 1, 1, 8'h12, 8'h34, 1, 0, 0, 0, 8'h00, 0);
        vecs[2]  = mk(1, 1, 0, 8'h3C, 8'h00, 1, 1, 0, 1, 8'h3C, 0);
        vecs[3]  = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h3C, 0);
        vecs[4]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0);
        vecs[5]  = mk(1, 1, 1, 8'hAA, 8'h55, 1, 1, 0, 1, 8'hAA, 0);
        vecs[6]  = mk(1, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 8'h55, 1);
        vecs[7]  = mk(1, 1, 1, 8'hAA, 8'h55, 1, 1, 0, 1, 8'hAA, 0);
        vecs[8]  = mk(1, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 8'h55, 1);
        vecs[9]  = mk(1, 0, 1, 8'h00, 8'h77, 0, 0, 0, 1, 8'h55, 1);
        vecs[10] = mk(1, 0, 1, 8'h00, 8'h77, 0, 0, 0, 1, 8'h55, 1);
        vecs[11] = mk(1, 0, 1, 8'h00, 8'h77, 0, 0, 0, 1, 8'h55, 1);
        vecs[12] = mk(1, 0, 1, 8'h00, 8'h77, 1, 0, 1, 1, 8'h77, 1);
        vecs[13] = mk(1, 1, 0, 8'h11, 8'h00, 1, 1, 0, 1, 8'h11, 0);
        vecs[14] = mk(1, 0, 1, 8'h00, 8'h22, 1, 0, 1, 1, 8'h22, 1);
        vecs[15] = mk(1, 1, 0, 8'h33, 8'h00, 1, 1, 0, 1, 8'h33, 0);
        vecs[16] = mk(1, 1, 0, 8'hF0, 8'h00, 1, 1, 0, 1, 8'hF0, 0);
        vecs[17] = mk(0, 1, 1, 8'hAA, 8'h55, 0, 0, 0, 0, 8'h00, 0);
        vecs[18] = mk(1, 1, 1, 8'hAA, 8'h55, 1, 1, 0, 1, 8'hAA, 0);
        vecs[19] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'hAA, 0);
        vecs[20] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'hAA, 0);
        vecs[21] = mk(1, 1, 1, 8'hAA, 8'h55, 1, 0, 1, 1, 8'h55, 1);

        rst_n = 1'b0;
        bus.req_a = 1'b0; bus.req_b = 1'b0;
        bus.data_a = '0; bus.data_b = '0; bus.out_ready = 1'b0;

        for (int i = 0; i < 22; i++) step(vecs[i], i);

        // Back-to-back A words with a fresh payload each cycle.
        step(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0), 100);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'(i * 16 + 1);
            step(mk(1, 1, 0, d, 8'h00, 1, 1, 0, 1, d, 0), 101 + i);
        end

`ifdef ARB_GRANT_CNT_EN
        step(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, 8'h00, 0), 200);
        check("cnt_a_reset", 200, cnt_a, 8'd0);
        check("cnt_b_reset", 200, cnt_b, 8'd0);
        for (int i = 0; i < 300; i++) begin
            step(mk(1, 1, 0, 8'h5A, 8'h00, 1, 1, 0, 1, 8'h5A, 0), 201);
            if (i == 9) check("cnt_a_10", 201, cnt_a, 8'd10);
        end
        check("cnt_a_sat", 202, cnt_a, 8'd255);
        check("cnt_b_zero", 202, cnt_b, 8'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
